// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the execute stage: operands and control in, forwarding
// result, multiplier busy and the registered EX/MEM fields out.
interface ex_stage_if;
  // Handshake: id_en marks the ID/EX entry as valid. mul_stall is the stage's
  // not-ready; while it is high, ID holds the entry unchanged. An entry is
  // consumed at an edge where mul_stall=0 and stall=0.
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0;
  logic [31:0] id_alu_in_1;
  logic [3:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [31:0] fwd_data;
  logic        mul_stall;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [31:0] ex_out;

  modport master (
    output id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
           id_mem_wr_data, id_dst_addr, id_gpr_we_,
    input  fwd_data, mul_stall, ex_en, ex_mem_op, ex_mem_wr_data,
           ex_dst_addr, ex_gpr_we_, ex_out
  );

  modport slave (
    input  id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
           id_mem_wr_data, id_dst_addr, id_gpr_we_,
    output fwd_data, mul_stall, ex_en, ex_mem_op, ex_mem_wr_data,
           ex_dst_addr, ex_gpr_we_, ex_out
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift-add multiplier,
// feeding the EX/MEM pipeline register.
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  ex_stage_if.slave  bus,
  output logic [1:0] o_dbg_state,
  output logic [5:0] o_dbg_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [5:0]  r_count;

  logic        r_ex_en;
  logic [3:0]  r_ex_mem_op;
  logic [31:0] r_ex_mem_wr_data;
  logic [4:0]  r_ex_dst_addr;
  logic        r_ex_gpr_we_;
  logic [31:0] r_ex_out;

  logic        w_mul_start;
  logic        w_mul_stall;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic [31:0] w_fwd;

  assign w_mul_start = bus.id_en && (bus.id_alu_op == OP_MUL) && !flush;
  assign w_mul_stall = ((r_state == S_IDLE) && w_mul_start) || (r_state == S_BUSY);
  assign w_shamt     = bus.id_alu_in_1[4:0];

  always_comb begin
    w_alu = 32'd0;
    case (bus.id_alu_op)
      OP_PASS: w_alu = bus.id_alu_in_0;
      OP_ADD:  w_alu = bus.id_alu_in_0 + bus.id_alu_in_1;
      OP_SUB:  w_alu = bus.id_alu_in_0 - bus.id_alu_in_1;
      OP_AND:  w_alu = bus.id_alu_in_0 & bus.id_alu_in_1;
      OP_OR:   w_alu = bus.id_alu_in_0 | bus.id_alu_in_1;
      OP_XOR:  w_alu = bus.id_alu_in_0 ^ bus.id_alu_in_1;
      OP_SLL:  w_alu = bus.id_alu_in_0 << w_shamt;
      OP_SRL:  w_alu = bus.id_alu_in_0 >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(bus.id_alu_in_0) >>> w_shamt);
      OP_SLT:  w_alu = {31'd0, $signed(bus.id_alu_in_0) < $signed(bus.id_alu_in_1)};
      OP_SLTU: w_alu = {31'd0, bus.id_alu_in_0 < bus.id_alu_in_1};
      OP_MUL:  w_alu = r_acc;
      default: w_alu = 32'd0;
    endcase
  end

  // Once the product is complete it is forwarded regardless of what ID presents.
  assign w_fwd = (r_state == S_DONE) ? r_acc : w_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_count  <= 6'd0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_acc    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= bus.id_alu_in_0;
            r_mplier <= bus.id_alu_in_1;
            r_acc    <= 32'd0;
            r_count  <= 6'd0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_count  <= r_count + 6'd1;
          if (r_count == 6'd31) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Leave only when the EX/MEM register takes the product.
          if (!stall) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (!stall && (flush || w_mul_stall))) begin
      r_ex_en          <= 1'b0;
      r_ex_mem_op      <= 4'd0;
      r_ex_mem_wr_data <= 32'd0;
      r_ex_dst_addr    <= 5'd0;
      r_ex_gpr_we_     <= 1'b1;
      r_ex_out         <= 32'd0;
    end else if (!stall) begin
      r_ex_en          <= bus.id_en;
      r_ex_mem_op      <= bus.id_en ? bus.id_mem_op : 4'd0;
      r_ex_mem_wr_data <= bus.id_mem_wr_data;
      r_ex_dst_addr    <= bus.id_dst_addr;
      r_ex_gpr_we_     <= bus.id_en ? bus.id_gpr_we_ : 1'b1;
      r_ex_out         <= w_fwd;
    end
  end

  assign bus.fwd_data       = w_fwd;
  assign bus.mul_stall      = w_mul_stall;
  assign bus.ex_en          = r_ex_en;
  assign bus.ex_mem_op      = r_ex_mem_op;
  assign bus.ex_mem_wr_data = r_ex_mem_wr_data;
  assign bus.ex_dst_addr    = r_ex_dst_addr;
  assign bus.ex_gpr_we_     = r_ex_gpr_we_;
  assign bus.ex_out         = r_ex_out;
  assign o_dbg_state        = r_state;
  assign o_dbg_count        = r_count;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, multiplier latency, stall/flush/reset
// interaction, with hand-computed expected values.
module tb_ex_stage;
  logic       clk;
  logic       reset;
  logic       stall;
  logic       flush;
  logic [1:0] dbg_state;
  logic [5:0] dbg_count;
  int         checks;
  int         failures;

  ex_stage_if bus();

  ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NV = 11;
  localparam logic [3:0]  OP_T [NV] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                        4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
  localparam logic [31:0] A_T [NV] = '{32'hDEADBEEF, 32'd5, 32'hF0F0F0F0,
                                       32'hF0F0F0F0, 32'hFFFF0000, 32'd1,
                                       32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                       32'hFFFFFFFF, 32'h1234};
  localparam logic [31:0] B_T [NV] = '{32'd5, 32'd7, 32'hFF00FF00, 32'h0F0F0000,
                                       32'h0F0F0F0F, 32'd33, 32'd31, 32'd4,
                                       32'd1, 32'd1, 32'd5};
  localparam logic [31:0] E_T [NV] = '{32'hDEADBEEF, 32'hFFFFFFFE, 32'hF000F000,
                                       32'hFFFFF0F0, 32'hF0F00F0F, 32'd2, 32'd1,
                                       32'hF8000000, 32'd1, 32'd0, 32'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] mop,
                       input logic [31:0] wd, input logic [4:0] dst, input logic we_);
    bus.id_en          = en;
    bus.id_alu_op      = op;
    bus.id_alu_in_0    = a;
    bus.id_alu_in_1    = b;
    bus.id_mem_op      = mop;
    bus.id_mem_wr_data = wd;
    bus.id_dst_addr    = dst;
    bus.id_gpr_we_     = we_;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b1);
    step(); step();
    reset = 1'b0;
    checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL rst_ex_en got=%0b exp=0", bus.ex_en); end
    checks++; if (bus.ex_gpr_we_ !== 1'b1) begin failures++; $display("FAIL rst_we got=%0b exp=1", bus.ex_gpr_we_); end
    checks++; if (bus.ex_out !== 32'd0) begin failures++; $display("FAIL rst_ex_out got=%h exp=0", bus.ex_out); end
    checks++; if (bus.ex_mem_op !== 4'd0) begin failures++; $display("FAIL rst_mem_op got=%h exp=0", bus.ex_mem_op); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    checks++; if (bus.mul_stall !== 1'b0) begin failures++; $display("FAIL rst_mul_stall got=%0b exp=0", bus.mul_stall); end
  endtask

  task automatic test_add();
    drive(1'b1, 4'd1, 32'hFFFFFFFF, 32'd2, 4'b1001, 32'hCAFEBABE, 5'd3, 1'b0);
    checks++; if (bus.fwd_data !== 32'd1) begin failures++; $display("FAIL add_fwd got=%h exp=00000001", bus.fwd_data); end
    checks++; if (bus.mul_stall !== 1'b0) begin failures++; $display("FAIL add_mul_stall got=%0b exp=0", bus.mul_stall); end
    step();
    checks++; if (bus.ex_out !== 32'd1) begin failures++; $display("FAIL add_ex_out got=%h exp=00000001", bus.ex_out); end
    checks++; if (bus.ex_dst_addr !== 5'd3) begin failures++; $display("FAIL add_dst got=%0d exp=3", bus.ex_dst_addr); end
    checks++; if (bus.ex_en !== 1'b1) begin failures++; $display("FAIL add_en got=%0b exp=1", bus.ex_en); end
    checks++; if (bus.ex_gpr_we_ !== 1'b0) begin failures++; $display("FAIL add_we got=%0b exp=0", bus.ex_gpr_we_); end
    checks++; if (bus.ex_mem_op !== 4'b1001) begin failures++; $display("FAIL add_mem_op got=%h exp=9", bus.ex_mem_op); end
    checks++; if (bus.ex_mem_wr_data !== 32'hCAFEBABE) begin failures++; $display("FAIL add_wr_data got=%h exp=cafebabe", bus.ex_mem_wr_data); end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, OP_T[i], A_T[i], B_T[i], 4'd0, 32'd0, i[4:0], 1'b0);
      step();
      checks++;
      if (bus.ex_out !== E_T[i]) begin
        failures++;
        $display("FAIL alu_op%0d got=%h exp=%h", OP_T[i], bus.ex_out, E_T[i]);
      end
    end
  endtask

  task automatic test_id_en_zero();
    drive(1'b0, 4'd11, 32'd3, 32'd4, 4'b1000, 32'h55, 5'd9, 1'b0);
    checks++; if (bus.mul_stall !== 1'b0) begin failures++; $display("FAIL noen_mul_stall got=%0b exp=0", bus.mul_stall); end
    step();
    checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL noen_en got=%0b exp=0", bus.ex_en); end
    checks++; if (bus.ex_mem_op !== 4'd0) begin failures++; $display("FAIL noen_mem_op got=%h exp=0", bus.ex_mem_op); end
    checks++; if (bus.ex_gpr_we_ !== 1'b1) begin failures++; $display("FAIL noen_we got=%0b exp=1", bus.ex_gpr_we_); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL noen_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_mul();
    int n;
    n = 0;
    drive(1'b1, 4'd11, 32'h00010001, 32'h0000FFFF, 4'd0, 32'd0, 5'd5, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (!bus.mul_stall) break;
      n++;
      step();
      checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL mul_bubble cyc=%0d got=%0b exp=0", n, bus.ex_en); end
    end
    checks++; if (n != 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", n); end
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL mul_done_state got=%0d exp=2", dbg_state); end
    checks++; if (bus.fwd_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL mul_fwd got=%h exp=ffffffff", bus.fwd_data); end
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b1);
    checks++; if (bus.ex_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mul_ex_out got=%h exp=ffffffff", bus.ex_out); end
    checks++; if (bus.ex_en !== 1'b1) begin failures++; $display("FAIL mul_ex_en got=%0b exp=1", bus.ex_en); end
    checks++; if (bus.ex_dst_addr !== 5'd5) begin failures++; $display("FAIL mul_dst got=%0d exp=5", bus.ex_dst_addr); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL mul_idle got=%0d exp=0", dbg_state); end
    step();
    checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL mul_one_capture got=%0b exp=0", bus.ex_en); end
  endtask

  task automatic test_stall_done();
    drive(1'b1, 4'd11, 32'd7, 32'd6, 4'd0, 32'd0, 5'd6, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == 2'd2) break;
      step();
    end
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL sd_reach_done got=%0d exp=2", dbg_state); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL sd_hold_state i=%0d got=%0d exp=2", i, dbg_state); end
      checks++; if (bus.fwd_data !== 32'd42) begin failures++; $display("FAIL sd_fwd i=%0d got=%h exp=2a", i, bus.fwd_data); end
      checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL sd_ex_held i=%0d got=%0b exp=0", i, bus.ex_en); end
    end
    stall = 1'b0;
    step();
    checks++; if (bus.ex_out !== 32'd42) begin failures++; $display("FAIL sd_ex_out got=%h exp=2a", bus.ex_out); end
    checks++; if (bus.ex_en !== 1'b1) begin failures++; $display("FAIL sd_ex_en got=%0b exp=1", bus.ex_en); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL sd_idle got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd11, 32'd3, 32'd5, 4'd0, 32'd0, 5'd7, 1'b0);
    checks++; if (bus.mul_stall !== 1'b1) begin failures++; $display("FAIL b2b_start got=%0b exp=1", bus.mul_stall); end
    step();
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL b2b_busy got=%0d exp=1", dbg_state); end
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == 2'd2) break;
      step();
    end
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b1);
    checks++; if (bus.ex_out !== 32'd15) begin failures++; $display("FAIL b2b_ex_out got=%h exp=0000000f", bus.ex_out); end
    checks++; if (bus.ex_dst_addr !== 5'd7) begin failures++; $display("FAIL b2b_dst got=%0d exp=7", bus.ex_dst_addr); end
  endtask

  task automatic test_flush_reset();
    drive(1'b1, 4'd11, 32'h1234, 32'h10, 4'd0, 32'd0, 5'd8, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == 2'd1 && dbg_count == 6'd10) break;
      step();
    end
    checks++; if (dbg_count !== 6'd10) begin failures++; $display("FAIL fl_reach_cnt10 got=%0d exp=10", dbg_count); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b1);
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL fl_state got=%0d exp=0", dbg_state); end
    checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL fl_ex_en got=%0b exp=0", bus.ex_en); end
    checks++; if (bus.ex_gpr_we_ !== 1'b1) begin failures++; $display("FAIL fl_we got=%0b exp=1", bus.ex_gpr_we_); end
    checks++; if (bus.mul_stall !== 1'b0) begin failures++; $display("FAIL fl_mul_stall got=%0b exp=0", bus.mul_stall); end
    drive(1'b1, 4'd1, 32'd1, 32'd1, 4'b0100, 32'h77, 5'd7, 1'b0);
    step();
    checks++; if (bus.ex_out !== 32'd2) begin failures++; $display("FAIL rs_pre_out got=%h exp=2", bus.ex_out); end
    stall = 1'b1;
    drive(1'b1, 4'd11, 32'd5, 32'd5, 4'd0, 32'd0, 5'd1, 1'b0);
    step(); step(); step();
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL rs_busy got=%0d exp=1", dbg_state); end
    checks++; if (bus.ex_out !== 32'd2) begin failures++; $display("FAIL rs_stall_hold got=%h exp=2", bus.ex_out); end
    reset = 1'b1;
    step();
    reset = 1'b0; stall = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 1'b1);
    checks++; if (bus.ex_out !== 32'd0) begin failures++; $display("FAIL rs_ex_out got=%h exp=0", bus.ex_out); end
    checks++; if (bus.ex_dst_addr !== 5'd0) begin failures++; $display("FAIL rs_dst got=%0d exp=0", bus.ex_dst_addr); end
    checks++; if (bus.ex_en !== 1'b0) begin failures++; $display("FAIL rs_en got=%0b exp=0", bus.ex_en); end
    checks++; if (bus.ex_mem_op !== 4'd0) begin failures++; $display("FAIL rs_mem_op got=%h exp=0", bus.ex_mem_op); end
    checks++; if (bus.ex_mem_wr_data !== 32'd0) begin failures++; $display("FAIL rs_wr_data got=%h exp=0", bus.ex_mem_wr_data); end
    checks++; if (bus.ex_gpr_we_ !== 1'b1) begin failures++; $display("FAIL rs_we got=%0b exp=1", bus.ex_gpr_we_); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rs_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_count !== 6'd0) begin failures++; $display("FAIL rs_count got=%0d exp=0", dbg_count); end
    checks++; if (bus.mul_stall !== 1'b0) begin failures++; $display("FAIL rs_mul_stall got=%0b exp=0", bus.mul_stall); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_id_en_zero();
    test_mul();
    test_stall_done();
    test_back_to_back();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: stall  in  1  hold EX/MEM register.
REQ-004 SHALL have: flush  in  1  load bubble, abort multiply.
REQ-005 SHALL have: id_en  in  1  ID/EX entry valid.
REQ-006 SHALL have: id_alu_op  in  4  ALU operation.
REQ-007 SHALL have: id_alu_in_0, id_alu_in_1  in  32 each  ALU operands.
REQ-008 SHALL have: id_mem_op  in  4  memory operation; bits [3:2]==00 means no access.
REQ-009 SHALL have: id_mem_wr_data  in  32  store data.
REQ-010 SHALL have: id_dst_addr  in  5  GPR write address.
REQ-011 SHALL have: id_gpr_we_  in  1  GPR write enable, active-low.
REQ-012 SHALL have: fwd_data  out  32  combinational current ALU/multiply result, for forwarding.
REQ-013 SHALL have: mul_stall  out  1  multiplier busy; upstream holds ID while high.
REQ-014 SHALL have EX/MEM outputs: ex_en 1, ex_mem_op 4, ex_mem_wr_data 32, ex_dst_addr 5, ex_gpr_we_ 1, ex_out 32, all registered.

Function
REQ-015 SHALL encode id_alu_op: 0 pass in_0, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT signed, 10 SLTU, 11 MUL, 12-15 result 0.
REQ-016 SHALL wrap ADD/SUB/MUL modulo 2^32; shifts use in_1[4:0]; SLT/SLTU give 32'd1 or 32'd0; MUL gives low 32 bits of product.
REQ-017 SHALL compute ops 0-10 and 12-15 combinationally, no stall.
REQ-018 SHALL implement MUL as a radix-2 shift-add FSM with states IDLE, BUSY, DONE.
REQ-019 IDLE->BUSY when id_en=1, id_alu_op=11, flush=0: load multiplicand=in_0, multiplier=in_1, acc=0, count=0.
REQ-020 Each BUSY cycle: add multiplicand to acc if multiplier[0]; shift multiplicand left 1, multiplier right 1; count+1; after 32nd iteration go to DONE.
REQ-021 mul_stall SHALL be 1 in IDLE when the start condition of REQ-019 holds, and throughout BUSY; 0 in DONE.
REQ-022 In DONE, fwd_data = acc; DONE->IDLE at the edge where the EX/MEM register captures (stall=0); with stall=1, DONE is held.
REQ-023 MUL latency: issue cycle 0, mul_stall high cycles 0-32, DONE cycle 33, ex_out valid cycle 34.
REQ-024 A MUL presented in the cycle after DONE->IDLE SHALL start a new multiply (back-to-back allowed).
REQ-025 flush=1 SHALL return the FSM to IDLE at the next edge from any state, without starting a multiply that cycle.
REQ-026 EX/MEM register priority at each edge: reset > stall > flush > mul_stall > normal load.
REQ-027 stall=1: hold all EX/MEM outputs.
REQ-028 flush=1 with stall=0: load bubble (ex_en=0, ex_mem_op=0, ex_gpr_we_=1, data/addr fields 0).
REQ-029 mul_stall=1 with stall=0, flush=0: load bubble, so no partial product reaches MEM.
REQ-030 Normal load: ex_en=id_en, ex_mem_op=id_mem_op, ex_mem_wr_data=id_mem_wr_data, ex_dst_addr=id_dst_addr, ex_gpr_we_=id_gpr_we_, ex_out=fwd_data.
REQ-031 id_en=0 SHALL load ex_en=0, ex_mem_op=0, ex_gpr_we_=1, and SHALL NOT start a multiply.

Reset
REQ-032 reset=1 at an edge: FSM IDLE, count/acc 0, ex_en=0, ex_mem_op=0, ex_mem_wr_data=0, ex_dst_addr=0, ex_gpr_we_=1, ex_out=0; overrides stall and flush.
REQ-033 reset during BUSY SHALL abort the multiply; mul_stall=0 in the following cycle unless a new MUL is presented.

Verification
REQ-034 ADD 0xFFFFFFFF+2, dst 3, we_=0 -> next cycle ex_out=0x00000001, ex_dst_addr=3, ex_en=1.
REQ-035 SRA 0x80000000 by 4; SLT 0xFFFFFFFF,1; SLTU same -> 0xF8000000, 1, 0 respectively.
REQ-036 MUL 0x00010001 x 0x0000FFFF -> mul_stall high 33 cycles, ex_en=0 meanwhile; then ex_out=0xFFFFFFFF for one capture.
REQ-037 MUL with stall=1 asserted in DONE for 3 cycles -> FSM holds DONE, fwd_data stable; capture on first stall=0 edge.
REQ-038 flush at BUSY count=10 -> next cycle FSM IDLE, bubble loaded; then reset mid-BUSY -> all outputs at reset values.
